// File: rtl/instr_cache_refill_ctrl_if.sv
// Bus bundle between the icache refill controller and its neighbours:
// fetch miss path, memory request/response channel and data/tag array writes.
// Signal names keep the controller's point of view (i_ = into controller).
// Optional critical-word-first output guarded by INSTR_CACHE_CWF_EN.

`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif

interface instr_cache_refill_ctrl_if #(
    parameter int unsigned LINE_BEATS = 8,
    parameter int unsigned BEAT_WIDTH = 64
);
    localparam int unsigned BEAT_IDX_W = $clog2(LINE_BEATS);

    // Fetch miss path
    logic                    i_miss_valid;
    logic [`PADDR_WIDTH-1:0] i_miss_paddr;
    logic                    o_miss_ready;
    // Memory request / response
    logic                    o_mem_req_valid;
    logic [`PADDR_WIDTH-1:0] o_mem_req_paddr;
    logic                    i_mem_req_ready;
    logic                    i_mem_resp_valid;
    logic [BEAT_WIDTH-1:0]   i_mem_resp_data;
    logic                    i_mem_resp_err;
    logic                    i_flush;
    // Data / tag array
    logic                    o_wr_en;
    logic [`PADDR_WIDTH-1:0] o_wr_paddr;
    logic [BEAT_IDX_W-1:0]   o_wr_beat;
    logic [BEAT_WIDTH-1:0]   o_wr_data;
    logic                    o_tag_wr_en;
    logic                    o_refill_done;
    logic                    o_refill_err;
`ifdef INSTR_CACHE_CWF_EN
    logic                    o_crit_valid;
`endif

    // Controller side
    modport master (
        input  i_miss_valid, i_miss_paddr, i_mem_req_ready, i_mem_resp_valid,
        input  i_mem_resp_data, i_mem_resp_err, i_flush,
        output o_miss_ready, o_mem_req_valid, o_mem_req_paddr, o_wr_en, o_wr_paddr,
        output o_wr_beat, o_wr_data, o_tag_wr_en, o_refill_done, o_refill_err
`ifdef INSTR_CACHE_CWF_EN
        , output o_crit_valid
`endif
    );

    // Environment side (fetch, memory, arrays)
    modport slave (
        output i_miss_valid, i_miss_paddr, i_mem_req_ready, i_mem_resp_valid,
        output i_mem_resp_data, i_mem_resp_err, i_flush,
        input  o_miss_ready, o_mem_req_valid, o_mem_req_paddr, o_wr_en, o_wr_paddr,
        input  o_wr_beat, o_wr_data, o_tag_wr_en, o_refill_done, o_refill_err
`ifdef INSTR_CACHE_CWF_EN
        , input o_crit_valid
`endif
    );
endinterface

// File: rtl/instr_cache_refill_ctrl.sv
// Instruction cache line refill controller: accepts one fetch miss, issues a
// single line read, streams returned beats into the data array one cycle
// later, then commits the tag (or reports an error / abandons on flush).
// Optional feature: INSTR_CACHE_CWF_EN (critical word first ordering).

`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module instr_cache_refill_ctrl #(
    parameter int unsigned LINE_BEATS = 8,
    parameter int unsigned BEAT_WIDTH = 64
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    instr_cache_refill_ctrl_if.master bus
);
    localparam int unsigned PADDR_W    = `PADDR_WIDTH;
    localparam int unsigned BEAT_IDX_W = $clog2(LINE_BEATS);
    localparam int unsigned LINE_BYTES = LINE_BEATS * BEAT_WIDTH / 8;
    localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);

    localparam logic [PADDR_W-1:0]    LINE_MASK = ~PADDR_W'((64'd1 << LINE_OFF_W) - 64'd1);
    localparam logic [BEAT_IDX_W:0]   CNT_FULL  = (BEAT_IDX_W + 1)'(LINE_BEATS);

`ifdef INSTR_CACHE_CWF_EN
    localparam int unsigned BEAT_OFF_W = $clog2(BEAT_WIDTH / 8);
    localparam logic [PADDR_W-1:0] BEAT_MASK = ~PADDR_W'((64'd1 << BEAT_OFF_W) - 64'd1);
`endif

    if (LINE_BEATS < 2 || (LINE_BEATS & (LINE_BEATS - 1)) != 0) begin : g_bad_line_beats
        $error("LINE_BEATS must be a power of 2 and at least 2");
    end
    if (BEAT_WIDTH % `INSTR_WIDTH != 0) begin : g_bad_beat_width
        $error("BEAT_WIDTH must be a multiple of INSTR_WIDTH");
    end

    typedef enum logic [2:0] {StIdle, StReq, StResp, StCommit, StDrain} state_e;

    state_e                state_q, state_d;
    logic [PADDR_W-1:0]    line_addr_q, line_addr_d;
    logic [PADDR_W-1:0]    req_addr_q, req_addr_d;
    logic                  flush_seen_q, flush_seen_d;
    logic                  err_q, err_d;
    logic [BEAT_IDX_W:0]   rcv_cnt_q, rcv_cnt_d;
    logic [BEAT_IDX_W-1:0] beat_idx_q, beat_idx_d;
    logic                  wr_en_q, wr_en_d;
    logic [BEAT_IDX_W-1:0] wr_beat_q, wr_beat_d;
    logic [BEAT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  crit_q, crit_d;
    logic                  miss_ready, req_valid, tag_wr_en, refill_done, refill_err;
    logic                  beat_take;

    // State and datapath registers; reset abandons any refill in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            line_addr_q  <= '0;
            req_addr_q   <= '0;
            flush_seen_q <= 1'b0;
            err_q        <= 1'b0;
            rcv_cnt_q    <= '0;
            beat_idx_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_beat_q    <= '0;
            wr_data_q    <= '0;
            crit_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            req_addr_q   <= req_addr_d;
            flush_seen_q <= flush_seen_d;
            err_q        <= err_d;
            rcv_cnt_q    <= rcv_cnt_d;
            beat_idx_q   <= beat_idx_d;
            wr_en_q      <= wr_en_d;
            wr_beat_q    <= wr_beat_d;
            wr_data_q    <= wr_data_d;
            crit_q       <= crit_d;
        end
    end

    // Next-state, beat accounting and per-state outputs.
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        req_addr_d   = req_addr_q;
        flush_seen_d = flush_seen_q;
        err_d        = err_q;
        rcv_cnt_d    = rcv_cnt_q;
        beat_idx_d   = beat_idx_q;
        wr_en_d      = 1'b0;
        wr_beat_d    = wr_beat_q;
        wr_data_d    = wr_data_q;
        miss_ready   = 1'b0;
        req_valid    = 1'b0;
        tag_wr_en    = 1'b0;
        refill_done  = 1'b0;
        refill_err   = 1'b0;
        // Beats beyond a full line are never counted.
        beat_take    = bus.i_mem_resp_valid && (rcv_cnt_q != CNT_FULL);

        unique case (state_q)
            StIdle: begin
                miss_ready = 1'b1;
                if (bus.i_miss_valid) begin
                    line_addr_d  = bus.i_miss_paddr & LINE_MASK;
`ifdef INSTR_CACHE_CWF_EN
                    req_addr_d   = bus.i_miss_paddr & BEAT_MASK;
                    beat_idx_d   = bus.i_miss_paddr[LINE_OFF_W-1:BEAT_OFF_W];
`else
                    req_addr_d   = bus.i_miss_paddr & LINE_MASK;
                    beat_idx_d   = '0;
`endif
                    rcv_cnt_d    = '0;
                    err_d        = 1'b0;
                    flush_seen_d = 1'b0;
                    state_d      = StReq;
                end
            end
            StReq: begin
                req_valid = 1'b1;
                if (bus.i_flush) begin
                    flush_seen_d = 1'b1;
                end
                if (bus.i_mem_req_ready) begin
                    state_d = (flush_seen_q || bus.i_flush) ? StDrain : StResp;
                end
            end
            StResp: begin
                if (beat_take) begin
                    rcv_cnt_d  = rcv_cnt_q + 1'b1;
                    beat_idx_d = beat_idx_q + 1'b1;
                    if (bus.i_mem_resp_err) begin
                        err_d = 1'b1;
                    end
                    // A flush on the same cycle as a beat drops that beat's write.
                    if (!bus.i_flush) begin
                        wr_en_d   = 1'b1;
                        wr_beat_d = beat_idx_q;
                        wr_data_d = bus.i_mem_resp_data;
                    end
                end
                // Full count means the last write is issuing now; commit next cycle.
                if (bus.i_flush) begin
                    state_d = StDrain;
                end else if (rcv_cnt_q == CNT_FULL) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (err_q) begin
                    refill_err = 1'b1;
                end else if (!bus.i_flush) begin
                    tag_wr_en   = 1'b1;
                    refill_done = 1'b1;
                end
                state_d = StIdle;
            end
            StDrain: begin
                if (beat_take) begin
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                end
                if (rcv_cnt_d == CNT_FULL) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // First write of the line carries the critical beat.
        crit_d = wr_en_d && (rcv_cnt_q == '0);
    end

    assign bus.o_miss_ready    = miss_ready;
    assign bus.o_mem_req_valid = req_valid;
    assign bus.o_mem_req_paddr = req_addr_q;
    assign bus.o_wr_en         = wr_en_q;
    assign bus.o_wr_paddr      = line_addr_q;
    assign bus.o_wr_beat       = wr_beat_q;
    assign bus.o_wr_data       = wr_data_q;
    assign bus.o_tag_wr_en     = tag_wr_en;
    assign bus.o_refill_done   = refill_done;
    assign bus.o_refill_err    = refill_err;
`ifdef INSTR_CACHE_CWF_EN
    assign bus.o_crit_valid    = crit_q;
`else
    logic unused_crit;
    assign unused_crit = crit_q;
`endif

    // Memory must not return beats before the line request has been accepted.
    a_no_early_beat : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q inside {StIdle, StReq}) |-> !bus.i_mem_resp_valid)
        else $error("response beat arrived before request handshake");

endmodule
